shot_sequencer: RTL and testbench
=================================

SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter NUM_BALLS, default 8: number of balls; index 0 is the cue ball.
REQ-002 Parameter SETTLE_FRAMES, default 15: frames with all balls stopped before a turn resolves.
REQ-003 Parameter MAX_POWER, default 40: shot power saturation value.
REQ-004 Parameter POWER_STEP, default 2: power increment per frame while charging.
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 startOfFrame  in  1  one-cycle pulse at the start of each 30 Hz frame.
REQ-008 shootKey  in  1  level, 1 = shot key held.
REQ-009 aimDirX, aimDirY  in  8 signed  aim direction, unit vector scaled by 64.
REQ-010 ballMoving  in  NUM_BALLS  bit i = 1 when ball i has nonzero velocity.
REQ-011 ballScored  in  NUM_BALLS  bit i is a one-cycle pulse when ball i drops into a pocket.
REQ-012 cueCollision  out  1  one-cycle pulse that loads cueVelocityX/Y into the cue ball's motion block.
REQ-013 cueVelocityX, cueVelocityY  out  32 signed  cue launch velocity, in the motion block's 1/64-pixel units.
REQ-014 power  out  6  current charge level.
REQ-015 aimEnable  out  1  high while the player may aim.
REQ-016 currentPlayer  out  1  player whose turn it is, 0 or 1.
REQ-017 score0, score1  out  4  per-player points.
REQ-018 foul  out  1  one-cycle pulse on cue-ball scratch.
REQ-019 cueRespawn  out  1  one-cycle pulse requesting the cue ball be returned to its start position.
REQ-020 gameOver  out  1  high once all object balls are potted.

Function
REQ-021 The FSM SHALL have states AIM, CHARGE, FIRE, ROLLING, SETTLE, RESOLVE and GAME_OVER; aimEnable SHALL be 1 only in AIM.
REQ-022 AIM: power=0; shootKey=1 SHALL move the FSM to CHARGE on the next clk.
REQ-023 CHARGE: on each startOfFrame with shootKey=1, power SHALL increase by POWER_STEP, saturating at MAX_POWER, never wrapping.
REQ-024 CHARGE: shootKey=0 SHALL go to FIRE if power>0, else to AIM.
REQ-025 FIRE SHALL last exactly 1 cycle, with:
  - cueCollision=1;
  - cueVelocityX = (aimDirX*power)>>>4 and cueVelocityY = (aimDirY*power)>>>4, arithmetic shift, sign-extended to 32 bits;
  - next state ROLLING.
REQ-026 cueVelocityX/Y SHALL hold their last value outside FIRE.
REQ-027 ROLLING: when ballMoving==0 is sampled, the FSM SHALL go to SETTLE and clear the settle counter.
REQ-028 SETTLE SHALL count startOfFrame pulses:
  - any ballMoving bit set returns to ROLLING;
  - the count reaching SETTLE_FRAMES goes to RESOLVE.
REQ-029 In ROLLING and SETTLE, a ballScored[0] pulse SHALL set the turn scratch flag.
REQ-030 In ROLLING and SETTLE, a ballScored[i] pulse (i>0) whose pottedMask bit i is still clear SHALL:
  - set pottedMask bit i;
  - increment turnPoints.
REQ-031 A repeat pulse for an already-potted ball SHALL be ignored.
REQ-032 Multiple bits set in the same cycle SHALL all be counted.
REQ-033 ballScored pulses SHALL be ignored in every state except ROLLING and SETTLE.
REQ-034 RESOLVE with the scratch flag set SHALL, in the same cycle:
  - pulse foul and cueRespawn;
  - credit no points;
  - toggle currentPlayer.
REQ-035 RESOLVE without scratch SHALL add turnPoints to the current player's score, saturating at 15.
REQ-036 RESOLVE without scratch SHALL toggle currentPlayer only if turnPoints==0.
REQ-037 RESOLVE SHALL clear turnPoints and the scratch flag, and SHALL last 1 cycle.
REQ-038 After RESOLVE the FSM SHALL go to GAME_OVER if pottedMask[NUM_BALLS-1:1] is all ones, else to AIM.
REQ-039 Object balls potted on a scratch turn SHALL remain in pottedMask.
REQ-040 GAME_OVER SHALL hold gameOver=1, ignore all inputs, and be left only through reset.
REQ-041 In CHARGE, startOfFrame and a shootKey fall in the same cycle: the power update SHALL NOT occur and the FSM SHALL take the CHARGE exit per REQ-024.

Reset
REQ-042 resetN=0 SHALL asynchronously set:
  - state=AIM;
  - power=0, cueVelocityX/Y=0;
  - cueCollision=foul=cueRespawn=gameOver=0;
  - currentPlayer=0, score0=score1=0;
  - pottedMask=0, turnPoints=0, scratch flag=0, settle counter=0.
REQ-043 Reset asserted in any state, including mid-shot, SHALL abort the turn with no pulse emitted.

Verification
REQ-044 Bench SHALL cover a charge-and-fire shot: hold shootKey 5 frames, aimDirX=64, aimDirY=0, then release -> power=10, one cueCollision pulse, cueVelocityX=40, cueVelocityY=0.
REQ-045 Bench SHALL cover power saturation: hold shootKey 30 frames -> power=40, never exceeding it; release with aimDirY=-64 -> cueVelocityY=-160.
REQ-046 Bench SHALL cover a pot: ballScored[3] twice plus ballScored[5] during ROLLING, then ballMoving=0 for 15 frames -> score0=2, currentPlayer stays 0.
REQ-047 Bench SHALL cover a scratch: ballScored[0] and ballScored[2] in the same cycle -> foul and cueRespawn pulse once, score0 unchanged, currentPlayer=1, ball 2 stays potted.
REQ-048 Bench SHALL cover settle interruption: ballMoving re-asserted at frame 10 of SETTLE -> ROLLING; resolve occurs only after 15 further clean frames.
REQ-049 Bench SHALL cover game end and reset: pot all 7 object balls -> gameOver=1 and shootKey ignored; pulse resetN=0 -> all outputs at REQ-042 values.

Source files
------------

// File: rtl/shot_sequencer_if.sv
// Shot sequencer bus: groups every non-clock, non-reset signal of the shot
// sequencer into one bundle.
//   Game-side inputs : startOfFrame, shootKey, aimDirX/Y, ballMoving, ballScored
//   Sequencer outputs: cueCollision, cueVelocityX/Y, power, aimEnable,
//                      currentPlayer, score0/1, foul, cueRespawn, gameOver
// Modports: master = the game/physics side driving the inputs,
//           slave  = the shot sequencer itself.
interface shot_sequencer_if #(
  parameter int NUM_BALLS = 8
);
  logic                        startOfFrame;
  logic                        shootKey;
  logic signed [7:0]           aimDirX;
  logic signed [7:0]           aimDirY;
  logic        [NUM_BALLS-1:0] ballMoving;
  logic        [NUM_BALLS-1:0] ballScored;

  logic                        cueCollision;
  logic signed [31:0]          cueVelocityX;
  logic signed [31:0]          cueVelocityY;
  logic        [5:0]           power;
  logic                        aimEnable;
  logic                        currentPlayer;
  logic        [3:0]           score0;
  logic        [3:0]           score1;
  logic                        foul;
  logic                        cueRespawn;
  logic                        gameOver;

  modport master (
    output startOfFrame, shootKey, aimDirX, aimDirY, ballMoving, ballScored,
    input  cueCollision, cueVelocityX, cueVelocityY, power, aimEnable,
           currentPlayer, score0, score1, foul, cueRespawn, gameOver
  );

  modport slave (
    input  startOfFrame, shootKey, aimDirX, aimDirY, ballMoving, ballScored,
    output cueCollision, cueVelocityX, cueVelocityY, power, aimEnable,
           currentPlayer, score0, score1, foul, cueRespawn, gameOver
  );
endinterface

// File: rtl/shot_sequencer.sv
// Shot sequencer for a two-player pool game. Runs one turn at a time:
// aim, charge shot power while the key is held, launch the cue ball, wait for
// the table to settle, then credit potted balls or penalise a scratch.
// Ports:
//   clk    - system clock
//   resetN - asynchronous active-low reset; aborts any turn in progress
//   bus    - shot_sequencer_if.slave (frame pulse, key, aim, ball status in;
//            launch pulse/velocity, power, turn and score state out)
module shot_sequencer #(
  parameter int NUM_BALLS     = 8,
  parameter int SETTLE_FRAMES = 15,
  parameter int MAX_POWER     = 40,
  parameter int POWER_STEP    = 2
) (
  input logic             clk,
  input logic             resetN,
  shot_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE_FRAMES + 1);
  localparam int PTS_W = $clog2(NUM_BALLS) + 1;

  typedef enum logic [2:0] {
    AIM, CHARGE, FIRE, ROLLING, SETTLE, RESOLVE, GAME_OVER
  } state_t;

  state_t                    state, nextState;
  logic        [5:0]         power;
  logic signed [31:0]        velX, velY;
  logic                      player;
  logic        [3:0]         score0, score1;
  logic        [NUM_BALLS-1:0] pottedMask;
  logic        [PTS_W-1:0]   turnPoints;
  logic                      scratch;
  logic        [CNT_W-1:0]   settleCnt;
  logic                      cueCollision, foul, cueRespawn, aimEnable, gameOver;
  logic        [NUM_BALLS-1:0] newBalls;
  logic                      allPotted;

  // Saturating power increment; computed in int so it can never wrap.
  function automatic logic [5:0] satPower(input logic [5:0] p);
    int sum;
    sum = int'(p) + POWER_STEP;
    return (sum >= MAX_POWER) ? 6'(MAX_POWER) : 6'(sum);
  endfunction

  // Launch velocity: (dir * power) >>> 4, floor-rounded, sign-extended to 32.
  function automatic logic signed [31:0] launchVel(input logic signed [7:0] dir,
                                                   input logic [5:0] p);
    logic signed [14:0] prod;
    logic signed [31:0] wide;
    prod = 15'(dir) * 15'($signed({1'b0, p}));
    wide = {{17{prod[14]}}, prod};
    return wide >>> 4;
  endfunction

  function automatic logic [3:0] satScore(input logic [3:0] s,
                                          input logic [PTS_W-1:0] pts);
    int sum;
    sum = int'(s) + int'(pts);
    return (sum > 15) ? 4'hF : 4'(sum);
  endfunction

  function automatic logic [PTS_W-1:0] countBits(input logic [NUM_BALLS-1:0] b);
    logic [PTS_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_BALLS; i++) n = n + PTS_W'(b[i]);
    return n;
  endfunction

  // Object balls newly potted this cycle; the cue ball (bit 0) never scores
  // and repeat pulses for already-potted balls drop out here.
  assign newBalls  = {bus.ballScored[NUM_BALLS-1:1] & ~pottedMask[NUM_BALLS-1:1], 1'b0};
  assign allPotted = &pottedMask[NUM_BALLS-1:1];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= AIM;
    else         state <= nextState;
  end

  always_comb begin
    nextState    = state;
    cueCollision = 1'b0;
    foul         = 1'b0;
    cueRespawn   = 1'b0;
    aimEnable    = 1'b0;
    gameOver     = 1'b0;
    case (state)
      AIM: begin
        aimEnable = 1'b1;
        if (bus.shootKey) nextState = CHARGE;
      end
      CHARGE: begin
        if (!bus.shootKey) nextState = (power != '0) ? FIRE : AIM;
      end
      FIRE: begin
        cueCollision = 1'b1;
        nextState    = ROLLING;
      end
      ROLLING: begin
        if (bus.ballMoving == '0) nextState = SETTLE;
      end
      SETTLE: begin
        // Motion takes priority over a frame pulse arriving in the same cycle.
        if (bus.ballMoving != '0)
          nextState = ROLLING;
        else if (bus.startOfFrame && settleCnt == CNT_W'(SETTLE_FRAMES - 1))
          nextState = RESOLVE;
      end
      RESOLVE: begin
        foul       = scratch;
        cueRespawn = scratch;
        nextState  = allPotted ? GAME_OVER : AIM;
      end
      GAME_OVER: gameOver = 1'b1;
      default:   nextState = AIM;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      power      <= '0;
      velX       <= '0;
      velY       <= '0;
      player     <= 1'b0;
      score0     <= '0;
      score1     <= '0;
      pottedMask <= '0;
      turnPoints <= '0;
      scratch    <= 1'b0;
      settleCnt  <= '0;
    end else begin
      case (state)
        AIM: power <= '0;
        CHARGE: begin
          // A release coinciding with a frame pulse launches at the old power.
          if (bus.shootKey && bus.startOfFrame) begin
            power <= satPower(power);
          end else if (!bus.shootKey && power != '0) begin
            // Latched on entry to FIRE so the velocity is valid with the pulse.
            velX <= launchVel(bus.aimDirX, power);
            velY <= launchVel(bus.aimDirY, power);
          end
        end
        ROLLING, SETTLE: begin
          pottedMask <= pottedMask | newBalls;
          turnPoints <= turnPoints + countBits(newBalls);
          if (bus.ballScored[0]) scratch <= 1'b1;
          if (state == ROLLING)
            settleCnt <= '0;
          else if (bus.ballMoving == '0 && bus.startOfFrame)
            settleCnt <= settleCnt + CNT_W'(1);
        end
        RESOLVE: begin
          power <= '0;
          if (scratch) begin
            player <= ~player;
          end else begin
            if (player) score1 <= satScore(score1, turnPoints);
            else        score0 <= satScore(score0, turnPoints);
            if (turnPoints == '0) player <= ~player;
          end
          turnPoints <= '0;
          scratch    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cueCollision  = cueCollision;
  assign bus.cueVelocityX  = velX;
  assign bus.cueVelocityY  = velY;
  assign bus.power         = power;
  assign bus.aimEnable     = aimEnable;
  assign bus.currentPlayer = player;
  assign bus.score0        = score0;
  assign bus.score1        = score1;
  assign bus.foul          = foul;
  assign bus.cueRespawn    = cueRespawn;
  assign bus.gameOver      = gameOver;

endmodule

// File: tb/tb_shot_sequencer.sv
// Testbench for shot_sequencer: directed turns (charge/fire, saturation, pot,
// scratch, settle interruption, game end, resets) checked against a
// turn-level scoring model and hand-computed literals.
module tb_shot_sequencer;
  localparam int NB = 8;
  localparam int SF = 15;
  localparam int MP = 40;
  localparam int PS = 2;

  logic clk    = 1'b0;
  logic resetN = 1'b0;

  shot_sequencer_if #(.NUM_BALLS(NB)) bus ();

  shot_sequencer #(
    .NUM_BALLS(NB), .SETTLE_FRAMES(SF), .MAX_POWER(MP), .POWER_STEP(PS)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- turn-level model ----------------
  int          expScore[2];
  int          expPlayer;
  bit [NB-1:0] expPotted;
  int          expTurnPts;
  bit          expScratch;
  int          expFires;
  int          expFouls;
  bit          modelValid = 1'b0;

  task automatic modelReset();
    expScore[0] = 0; expScore[1] = 0; expPlayer = 0; expPotted = '0;
    expTurnPts = 0; expScratch = 1'b0;
  endtask

  task automatic modelPot(input bit [NB-1:0] bits);
    if (bits[0]) expScratch = 1'b1;
    for (int i = 1; i < NB; i++)
      if (bits[i] && !expPotted[i]) begin
        expPotted[i] = 1'b1;
        expTurnPts++;
      end
  endtask

  task automatic modelResolve();
    if (expScratch) begin
      expFouls++;
      expPlayer = 1 - expPlayer;
    end else begin
      expScore[expPlayer] = (expScore[expPlayer] + expTurnPts > 15) ? 15
                            : expScore[expPlayer] + expTurnPts;
      if (expTurnPts == 0) expPlayer = 1 - expPlayer;
    end
    expTurnPts = 0;
    expScratch = 1'b0;
  endtask

  function automatic int expPower(input int frames);
    return (frames * PS > MP) ? MP : frames * PS;
  endfunction

  // Floor of dir*power/16.
  function automatic int expVel(input int dir, input int p);
    int v;
    v = dir * p;
    return (v >= 0) ? v / 16 : -((-v + 15) / 16);
  endfunction

  // ---------------- compare process ----------------
  int                 collCnt = 0;
  int                 foulCnt = 0;
  int                 respCnt = 0;
  logic signed [31:0] lastVX, lastVY;
  logic        [5:0]  lastPow;

  always @(negedge clk) begin
    if (resetN) begin
      if (bus.cueCollision) begin
        collCnt++;
        lastVX  = bus.cueVelocityX;
        lastVY  = bus.cueVelocityY;
        lastPow = bus.power;
      end
      if (bus.foul)       foulCnt++;
      if (bus.cueRespawn) respCnt++;
      check("powerMax", (bus.power <= 6'(MP)) ? 1 : 0, 1);
      if (modelValid) begin
        check("score0", bus.score0, expScore[0]);
        check("score1", bus.score1, expScore[1]);
        check("currentPlayer", bus.currentPlayer, expPlayer);
        check("gameOver", bus.gameOver, (&expPotted[NB-1:1]) ? 1 : 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit key);
    bus.shootKey     = key;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    repeat (3) tick();
  endtask

  // Aim, hold the key for 'frames' frames, release (optionally together with
  // a frame pulse) and wait until the ball is rolling.
  task automatic shoot(input string name, input int dx, input int dy,
                       input int frames, input bit releaseOnFrame);
    int p;
    bus.aimDirX    = 8'(dx);
    bus.aimDirY    = 8'(dy);
    bus.ballMoving = '1;
    bus.shootKey   = 1'b1;
    tick();
    repeat (frames) frame(1'b1);
    p = expPower(frames);
    check({name, ".power"}, bus.power, p);
    if (releaseOnFrame) begin
      bus.startOfFrame = 1'b1;
      bus.shootKey     = 1'b0;
      tick();
      bus.startOfFrame = 1'b0;
    end else begin
      bus.shootKey = 1'b0;
      tick();
    end
    tick();
    expFires++;
    check({name, ".fires"}, collCnt, expFires);
    check({name, ".firePower"}, lastPow, p);
    check({name, ".velX"}, lastVX, expVel(dx, p));
    check({name, ".velY"}, lastVY, expVel(dy, p));
  endtask

  task automatic pot(input bit [NB-1:0] bits);
    bus.ballScored = bits;
    tick();
    bus.ballScored = '0;
    modelPot(bits);
  endtask

  task automatic settleAndResolve();
    modelValid     = 1'b0;
    bus.ballMoving = '0;
    tick();
    repeat (SF) frame(1'b0);
    modelResolve();
    modelValid = 1'b1;
  endtask

  task automatic checkResetState(input string name);
    check({name, ".power"}, bus.power, 0);
    check({name, ".velX"}, bus.cueVelocityX, 0);
    check({name, ".velY"}, bus.cueVelocityY, 0);
    check({name, ".cueCollision"}, bus.cueCollision, 0);
    check({name, ".foul"}, bus.foul, 0);
    check({name, ".cueRespawn"}, bus.cueRespawn, 0);
    check({name, ".gameOver"}, bus.gameOver, 0);
    check({name, ".player"}, bus.currentPlayer, 0);
    check({name, ".score0"}, bus.score0, 0);
    check({name, ".score1"}, bus.score1, 0);
    check({name, ".aimEnable"}, bus.aimEnable, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, end of test expected");
    $fatal(1);
  end

  initial begin
    bus.startOfFrame = 1'b0;
    bus.shootKey     = 1'b0;
    bus.aimDirX      = '0;
    bus.aimDirY      = '0;
    bus.ballMoving   = '0;
    bus.ballScored   = '0;
    expFires = 0;
    expFouls = 0;
    modelReset();
    repeat (2) tick();
    checkResetState("reset");
    resetN = 1'b1;
    tick();
    modelValid = 1'b1;

    // Pot pulse while aiming must be ignored (ball 1 stays on the table).
    bus.ballScored = 8'b0000_0010;
    tick();
    bus.ballScored = '0;

    // Charge 5 frames, straight shot, then pot 3 (twice) and 5.
    shoot("shotA", 64, 0, 5, 1'b0);
    check("shotA.velXLit", lastVX, 40);
    check("shotA.velYLit", lastVY, 0);
    check("shotA.oneCollision", collCnt, 1);
    pot(8'b0000_1000);
    pot(8'b0000_1000);
    pot(8'b0010_0000);
    settleAndResolve();
    check("shotA.score0Lit", bus.score0, 2);
    check("shotA.playerLit", bus.currentPlayer, 0);
    check("shotA.aimEnable", bus.aimEnable, 1);

    // Saturated charge, then scratch together with ball 2.
    shoot("shotB", 0, -64, 30, 1'b0);
    check("shotB.powerLit", lastPow, 40);
    check("shotB.velYLit", lastVY, -160);
    pot(8'b0000_0101);
    settleAndResolve();
    check("shotB.foulCnt", foulCnt, expFouls);
    check("shotB.respawnCnt", respCnt, expFouls);
    check("shotB.foulLit", foulCnt, 1);
    check("shotB.score0Lit", bus.score0, 2);
    check("shotB.playerLit", bus.currentPlayer, 1);

    // Release coinciding with a frame pulse; settle interrupted at frame 10.
    shoot("shotC", -45, 37, 2, 1'b1);
    check("shotC.velXLit", lastVX, -12);
    check("shotC.velYLit", lastVY, 9);
    modelValid     = 1'b0;
    bus.ballMoving = '0;
    tick();
    repeat (10) frame(1'b0);
    bus.ballMoving = 8'h10;
    repeat (2) tick();
    bus.ballMoving = '0;
    tick();
    repeat (SF - 1) frame(1'b0);
    check("shotC.noEarlyResolve", bus.aimEnable, 0);
    frame(1'b0);
    check("shotC.resolved", bus.aimEnable, 1);
    modelResolve();
    modelValid = 1'b1;
    check("shotC.playerLit", bus.currentPlayer, 0);

    // Pot the remaining object balls (2 again is a repeat) -> game over.
    shoot("shotD", 64, 0, 3, 1'b0);
    pot(8'b1101_0110);
    settleAndResolve();
    check("shotD.score0Lit", bus.score0, 6);
    check("shotD.gameOverLit", bus.gameOver, 1);
    check("shotD.aimEnable", bus.aimEnable, 0);

    // Everything is ignored in game over.
    bus.shootKey = 1'b1;
    repeat (5) frame(1'b1);
    bus.ballScored = '1;
    tick();
    bus.ballScored = '0;
    bus.shootKey   = 1'b0;
    repeat (3) tick();
    check("gameOver.noFire", collCnt, expFires);
    check("gameOver.power", bus.power, 0);
    check("gameOver.hold", bus.gameOver, 1);

    // Asynchronous reset out of game over.
    modelValid = 1'b0;
    resetN     = 1'b0;
    #2;
    checkResetState("goReset");
    @(posedge clk);
    #1;
    resetN = 1'b1;
    modelReset();
    modelValid = 1'b1;

    // Reset mid-charge, with the key released in the same instant.
    bus.aimDirX  = 8'sd64;
    bus.shootKey = 1'b1;
    tick();
    repeat (3) frame(1'b1);
    check("midShot.power", bus.power, 6);
    modelValid   = 1'b0;
    resetN       = 1'b0;
    bus.shootKey = 1'b0;
    #2;
    checkResetState("midShotReset");
    repeat (2) tick();
    resetN = 1'b1;
    modelValid = 1'b1;
    repeat (3) tick();
    check("midShot.noFire", collCnt, expFires);
    check("midShot.noFoul", foulCnt, expFouls);
    check("midShot.aimEnable", bus.aimEnable, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
